// File: rtl/rename_unit.sv
// Register rename stage: maps architectural sources and destinations of a
// decode group onto physical registers through a register alias table (RAT)
// and a circular free list, with intra-group bypass and a one-deep
// registered output stage toward dispatch.
module rename_unit #(
   parameter int WIDTH    = 2,
   parameter int NUM_AREG = 32,
   parameter int NUM_PREG = 64,
   parameter int PW       = $clog2(NUM_PREG),
   parameter int AW       = $clog2(NUM_AREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH*AW-1:0] in_rs1,
   input  logic [WIDTH*AW-1:0] in_rs2,
   input  logic [WIDTH*AW-1:0] in_rd,
   input  logic [WIDTH-1:0]    in_we,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH*PW-1:0] out_ps1,
   output logic [WIDTH*PW-1:0] out_ps2,
   output logic [WIDTH*PW-1:0] out_pd,
   output logic [WIDTH*PW-1:0] out_old_pd,
   input  logic [WIDTH-1:0]    ret_valid,
   input  logic [WIDTH*PW-1:0] ret_preg,
   output logic [PW:0]         free_count,
   output logic                err_overflow
);

   localparam int unsigned DEPTH = NUM_PREG - NUM_AREG;
   localparam int          QW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW    = PW + 1;

   logic [PW-1:0]       rat  [NUM_AREG];
   logic [PW-1:0]       fifo [DEPTH];
   logic [QW-1:0]       head;
   logic [QW-1:0]       tail;

   logic [WIDTH-1:0]    alloc;
   logic [PW-1:0]       new_pd [WIDTH];
   logic [CW-1:0]       n_alloc;
   logic                accept;

   logic [WIDTH*PW-1:0] nxt_ps1;
   logic [WIDTH*PW-1:0] nxt_ps2;
   logic [WIDTH*PW-1:0] nxt_pd;
   logic [WIDTH*PW-1:0] nxt_old;

   logic [WIDTH-1:0]    push_en;
   logic [QW-1:0]       push_idx [WIDTH];
   logic [CW-1:0]       n_push;
   logic                ovf;

   // Pointer advance modulo the free-list depth; offsets never exceed
   // WIDTH, so a single conditional subtract suffices when DEPTH >= WIDTH.
   function automatic logic [QW-1:0] wrap_add(input logic [QW-1:0] base,
                                              input int unsigned   off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= DEPTH) begin
         sum = sum - DEPTH;
      end
      return sum[QW-1:0];
   endfunction

   // A group is taken only when the output slot frees up this cycle and the
   // free list can cover every allocating lane.
   assign in_ready = (!out_valid || out_ready) && (free_count >= n_alloc);
   assign accept   = in_valid && in_ready;

   // Decide which lanes allocate and hand them consecutive free-list
   // entries starting at head, in lane order.
   always_comb begin
      int unsigned cnt;
      cnt   = 0;
      alloc = '0;
      for (int j = 0; j < WIDTH; j++) begin
         new_pd[j] = '0;
         if (in_we[j] && (in_rd[j*AW +: AW] != '0)) begin
            alloc[j]  = 1'b1;
            new_pd[j] = fifo[wrap_add(head, cnt)];
            cnt       = cnt + 1;
         end
      end
      n_alloc = CW'(cnt);
   end

   // Source and previous-destination lookup: start from the RAT as it was
   // before the group, then let the latest earlier lane writing the same
   // register override it.
   always_comb begin
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic [AW-1:0] ad;
      logic [PW-1:0] p1;
      logic [PW-1:0] p2;
      logic [PW-1:0] po;
      nxt_ps1 = '0;
      nxt_ps2 = '0;
      nxt_pd  = '0;
      nxt_old = '0;
      a1 = '0;
      a2 = '0;
      ad = '0;
      p1 = '0;
      p2 = '0;
      po = '0;
      for (int j = 0; j < WIDTH; j++) begin
         a1 = in_rs1[j*AW +: AW];
         a2 = in_rs2[j*AW +: AW];
         ad = in_rd[j*AW +: AW];
         p1 = (a1 == '0) ? '0 : rat[a1];
         p2 = (a2 == '0) ? '0 : rat[a2];
         po = rat[ad];
         for (int i = 0; i < j; i++) begin
            if (alloc[i]) begin
               if (in_rd[i*AW +: AW] == a1) p1 = new_pd[i];
               if (in_rd[i*AW +: AW] == a2) p2 = new_pd[i];
               if (in_rd[i*AW +: AW] == ad) po = new_pd[i];
            end
         end
         if (!alloc[j]) begin
            po = '0;
         end
         nxt_ps1[j*PW +: PW] = p1;
         nxt_ps2[j*PW +: PW] = p2;
         nxt_pd[j*PW +: PW]  = new_pd[j];
         nxt_old[j*PW +: PW] = po;
      end
   end

   // Retirement pushes non-zero pregs at tail in lane order; slots vacated
   // by this cycle's allocation count as room, anything beyond capacity is
   // dropped and flagged.
   always_comb begin
      int unsigned room;
      int unsigned cnt;
      room    = DEPTH - 32'(free_count) + (accept ? 32'(n_alloc) : 32'd0);
      cnt     = 0;
      push_en = '0;
      ovf     = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
         push_idx[j] = '0;
         if (ret_valid[j] && (ret_preg[j*PW +: PW] != '0)) begin
            if (cnt < room) begin
               push_en[j]  = 1'b1;
               push_idx[j] = wrap_add(tail, cnt);
               cnt         = cnt + 1;
            end else begin
               ovf = 1'b1;
            end
         end
      end
      n_push = CW'(cnt);
   end

   // Output stage: load on accept, hold while dispatch stalls, drop the
   // valid once dispatch takes the group and nothing new arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_ps1    <= '0;
         out_ps2    <= '0;
         out_pd     <= '0;
         out_old_pd <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_ps1    <= nxt_ps1;
         out_ps2    <= nxt_ps2;
         out_pd     <= nxt_pd;
         out_old_pd <= nxt_old;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

   // RAT update on accept; ascending lane order means the highest lane
   // writing a given register wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < NUM_AREG; a++) begin
            rat[a] <= PW'(a);
         end
      end else if (accept) begin
         for (int j = 0; j < WIDTH; j++) begin
            if (alloc[j]) begin
               rat[in_rd[j*AW +: AW]] <= new_pd[j];
            end
         end
      end
   end

   // Free-list storage, pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo[i] <= PW'(NUM_AREG + i);
         end
         head         <= '0;
         tail         <= '0;
         free_count   <= CW'(DEPTH);
         err_overflow <= 1'b0;
      end else begin
         for (int j = 0; j < WIDTH; j++) begin
            if (push_en[j]) begin
               fifo[push_idx[j]] <= ret_preg[j*PW +: PW];
            end
         end
         if (accept) begin
            head <= wrap_add(head, 32'(n_alloc));
         end
         tail       <= wrap_add(tail, 32'(n_push));
         free_count <= free_count - (accept ? n_alloc : '0) + n_push;
         if (ovf) begin
            err_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: table of rename groups with
// hand-derived results fed through a scoreboard queue, plus hand-written
// sequences for stall, reset mid-handshake, overflow and free-list limits.
module tb_rename_unit;

   localparam int W  = 2;
   localparam int NA = 32;
   localparam int NP = 64;
   localparam int PW = 6;
   localparam int AW = 5;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W*AW-1:0] in_rs1;
   logic [W*AW-1:0] in_rs2;
   logic [W*AW-1:0] in_rd;
   logic [W-1:0]    in_we;
   logic            out_valid;
   logic            out_ready;
   logic [W*PW-1:0] out_ps1;
   logic [W*PW-1:0] out_ps2;
   logic [W*PW-1:0] out_pd;
   logic [W*PW-1:0] out_old_pd;
   logic [W-1:0]    ret_valid;
   logic [W*PW-1:0] ret_preg;
   logic [PW:0]     free_count;
   logic            err_overflow;

   typedef struct packed {
      logic [7:0]      id;
      logic [W*AW-1:0] rs1;
      logic [W*AW-1:0] rs2;
      logic [W*AW-1:0] rd;
      logic [W-1:0]    we;
      logic [W*PW-1:0] ps1;
      logic [W*PW-1:0] ps2;
      logic [W*PW-1:0] pd;
      logic [W*PW-1:0] old;
      logic [PW:0]     fc;
   } vec_t;

   vec_t tbl [8];
   vec_t sb [$];
   int   checks = 0;
   int   errors = 0;

   rename_unit #(.WIDTH(W), .NUM_AREG(NA), .NUM_PREG(NP)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_rd        (in_rd),
      .in_we        (in_we),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_ps1      (out_ps1),
      .out_ps2      (out_ps2),
      .out_pd       (out_pd),
      .out_old_pd   (out_old_pd),
      .ret_valid    (ret_valid),
      .ret_preg     (ret_preg),
      .free_count   (free_count),
      .err_overflow (err_overflow)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input int id,
                               input logic [W*AW-1:0] rs1, input logic [W*AW-1:0] rs2,
                               input logic [W*AW-1:0] rd, input logic [W-1:0] we,
                               input logic [W*PW-1:0] ps1, input logic [W*PW-1:0] ps2,
                               input logic [W*PW-1:0] pd, input logic [W*PW-1:0] old,
                               input int fc);
      vec_t v;
      v.id  = 8'(id);
      v.rs1 = rs1;
      v.rs2 = rs2;
      v.rd  = rd;
      v.we  = we;
      v.ps1 = ps1;
      v.ps2 = ps2;
      v.pd  = pd;
      v.old = old;
      v.fc  = 7'(fc);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      vec_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_group actual=out_pd %0d expected=no group", out_pd);
      end else begin
         e = sb.pop_front();
         chk($sformatf("ps1[%0d]", e.id), 64'(out_ps1), 64'(e.ps1));
         chk($sformatf("ps2[%0d]", e.id), 64'(out_ps2), 64'(e.ps2));
         chk($sformatf("pd[%0d]", e.id), 64'(out_pd), 64'(e.pd));
         chk($sformatf("old_pd[%0d]", e.id), 64'(out_old_pd), 64'(e.old));
         chk($sformatf("free_count[%0d]", e.id), 64'(free_count), 64'(e.fc));
      end
   endtask

   // Scoreboard consumer: compare each group as dispatch takes it
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checkOutput();
      end
   end

   task automatic drive(input vec_t v);
      in_rs1 = v.rs1;
      in_rs2 = v.rs2;
      in_rd  = v.rd;
      in_we  = v.we;
   endtask

   task automatic applyStimulus(input vec_t v);
      int n;
      n = 0;
      drive(v);
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout[%0d] actual=in_ready 0 expected=1", v.id);
      end else begin
         sb.push_back(v);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_we    = '0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Safety net so the run always ends
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_rs1    = '0;
      in_rs2    = '0;
      in_rd     = '0;
      in_we     = '0;
      out_ready = 1'b1;
      ret_valid = '0;
      ret_preg  = '0;

      tbl[0] = mk(0, {5'd5, 5'd1}, {5'd3, 5'd2}, {5'd6, 5'd5}, 2'b11,
                  {6'd32, 6'd1}, {6'd3, 6'd2}, {6'd33, 6'd32}, {6'd6, 6'd5}, 30);
      tbl[1] = mk(1, {5'd7, 5'd0}, {5'd5, 5'd6}, {5'd7, 5'd7}, 2'b11,
                  {6'd34, 6'd0}, {6'd32, 6'd33}, {6'd35, 6'd34}, {6'd34, 6'd7}, 28);
      tbl[2] = mk(2, {5'd6, 5'd7}, {5'd5, 5'd0}, {5'd0, 5'd9}, 2'b10,
                  {6'd33, 6'd35}, {6'd32, 6'd0}, 12'd0, 12'd0, 28);
      tbl[3] = mk(3, {5'd3, 5'd1}, {5'd7, 5'd2}, {5'd3, 5'd3}, 2'b10,
                  {6'd3, 6'd1}, {6'd35, 6'd2}, {6'd36, 6'd0}, {6'd3, 6'd0}, 27);
      tbl[4] = mk(4, {5'd1, 5'd3}, {5'd2, 5'd1}, {5'd2, 5'd1}, 2'b11,
                  {6'd37, 6'd36}, {6'd2, 6'd1}, {6'd38, 6'd37}, {6'd2, 6'd1}, 25);
      tbl[5] = mk(5, {5'd0, 5'd7}, {5'd0, 5'd1}, {5'd0, 5'd8}, 2'b01,
                  {6'd0, 6'd35}, {6'd0, 6'd37}, {6'd0, 6'd39}, {6'd0, 6'd8}, 24);
      tbl[6] = mk(6, {5'd1, 5'd8}, {5'd9, 5'd5}, 10'd0, 2'b00,
                  {6'd37, 6'd39}, {6'd9, 6'd32}, 12'd0, 12'd0, 24);
      tbl[7] = mk(7, {5'd1, 5'd8}, {5'd4, 5'd7}, {5'd0, 5'd4}, 2'b01,
                  {6'd1, 6'd8}, {6'd32, 6'd7}, {6'd0, 6'd32}, {6'd0, 6'd4}, 31);

      #1 rst = 1'b1;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pd", 64'(out_pd), 64'd0);
      chk("rst_free_count", 64'(free_count), 64'd32);
      chk("rst_err", 64'(err_overflow), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("ready_idle", 64'(in_ready), 64'd1);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(tbl[i]);
      end
      drain();

      // Dispatch stall: held group must stay put, a new group stays blocked
      out_ready = 1'b0;
      applyStimulus(tbl[5]);
      v = mk(50, 10'd0, 10'd0, {5'd0, 5'd9}, 2'b01, 12'd0, 12'd0, 12'd0, 12'd0, 0);
      drive(v);
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_pd", 64'(out_pd), 64'(tbl[5].pd));
         chk("stall_ps1", 64'(out_ps1), 64'(tbl[5].ps1));
         chk("stall_old", 64'(out_old_pd), 64'(tbl[5].old));
         chk("stall_ready", 64'(in_ready), 64'd0);
         chk("stall_fc", 64'(free_count), 64'd24);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_we     = '0;
      out_ready = 1'b1;
      applyStimulus(tbl[6]);
      drain();

      // Reset while a group is held: it must vanish with its allocation
      out_ready = 1'b0;
      drive(tbl[5]);
      in_valid = 1'b1;
      #1;
      chk("pre_rst_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_we    = '0;
      chk("held_valid", 64'(out_valid), 64'd1);
      chk("held_fc", 64'(free_count), 64'd23);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_pd", 64'(out_pd), 64'd0);
      chk("async_rst_ps1", 64'(out_ps1), 64'd0);
      chk("async_rst_fc", 64'(free_count), 64'd32);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;

      // Release into a full free list
      ret_valid = 2'b01;
      ret_preg  = {6'd0, 6'd40};
      #1;
      chk("ovf_before", 64'(err_overflow), 64'd0);
      @(posedge clk);
      #1;
      ret_valid = '0;
      ret_preg  = '0;
      chk("ovf_set", 64'(err_overflow), 64'd1);
      chk("ovf_fc", 64'(free_count), 64'd32);

      applyStimulus(tbl[7]);

      // Drain the free list down to a single entry
      for (int k = 0; k < 15; k++) begin
         v = mk(100 + k, 10'd0, 10'd0, {5'd11, 5'd10}, 2'b11, 12'd0, 12'd0,
                {6'(34 + 2*k), 6'(33 + 2*k)},
                (k == 0) ? {6'd11, 6'd10} : {6'(32 + 2*k), 6'(31 + 2*k)},
                29 - 2*k);
         applyStimulus(v);
      end

      // Two-lane group waits for a release; ready the cycle after it lands
      v = mk(120, 10'd0, 10'd0, {5'd14, 5'd13}, 2'b11, 12'd0, 12'd0,
             {6'd5, 6'd63}, {6'd14, 6'd13}, 0);
      drive(v);
      in_valid = 1'b1;
      #1;
      chk("fc_before_release", 64'(free_count), 64'd1);
      chk("ready_short", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("ready_short2", 64'(in_ready), 64'd0);
      ret_valid = 2'b01;
      ret_preg  = {6'd0, 6'd5};
      #1;
      chk("ready_same_cycle", 64'(in_ready), 64'd0);
      sb.push_back(v);
      @(posedge clk);
      #1;
      ret_valid = '0;
      ret_preg  = '0;
      chk("ready_after_release", 64'(in_ready), 64'd1);
      chk("fc_after_release", 64'(free_count), 64'd2);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_we    = '0;

      // Empty free list blocks even a single allocation
      v = mk(121, 10'd0, 10'd0, {5'd0, 5'd15}, 2'b01, 12'd0, 12'd0, 12'd0, 12'd0, 0);
      drive(v);
      in_valid = 1'b1;
      #1;
      chk("fc_empty", 64'(free_count), 64'd0);
      chk("ready_empty", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_we    = '0;
      chk("fc_empty_hold", 64'(free_count), 64'd0);
      chk("ovf_sticky", 64'(err_overflow), 64'd1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
